// File: rtl/health_pkg.sv
// Shared types and defaults for the fighter health manager.
package health_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FIGHT,
    ST_KO
  } state_t;

  localparam logic [1:0] WIN_NONE   = 2'b00;
  localparam logic [1:0] WIN_RYU    = 2'b01;
  localparam logic [1:0] WIN_AKUMA  = 2'b10;
  localparam logic [1:0] WIN_DOUBLE = 2'b11;

  localparam int unsigned MAX_HEALTH_C    = 245;
  localparam int unsigned INVULN_FRAMES_C = 30;

endpackage

// File: rtl/health_manager_player.sv
// One fighter's health: pending damage, saturating subtract, invulnerability
// window and, with HEALTH_DRAIN_ANIM_EN, a draining displayed-health register.
module player_health
  import health_pkg::*;
#(
  parameter int unsigned MAX_HEALTH    = MAX_HEALTH_C,
  parameter int unsigned INVULN_FRAMES = INVULN_FRAMES_C
`ifdef HEALTH_DRAIN_ANIM_EN
  , parameter int unsigned DRAIN_STEP  = 2
`endif
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_reload,
  input  logic       i_en,
  input  logic       i_tick,
  input  logic       i_hit,
  input  logic [7:0] i_dmg,
  output logic [7:0] o_true_health,
  output logic [7:0] o_disp_health,
  output logic       o_zero
);

  localparam logic [7:0] MAX_H = 8'(MAX_HEALTH);
  localparam logic [7:0] INV_F = 8'(INVULN_FRAMES);

  logic [8:0] r_pending;
  logic       r_armed;
  logic [7:0] r_invuln;
  logic [7:0] r_true;

  logic       w_accept;
  logic       w_tick;
  logic [8:0] w_sum;
  logic [8:0] w_pend_add;
  logic [7:0] w_true_next;

  assign w_accept    = i_en & i_hit & (r_invuln == '0);
  assign w_tick      = i_en & i_tick;
  assign w_sum       = r_pending + {1'b0, i_dmg};
  assign w_pend_add  = (w_sum > 9'd255) ? 9'd255 : w_sum;
  assign w_true_next = ({1'b0, r_true} <= r_pending) ? '0 : (r_true - r_pending[7:0]);

  // r_armed remembers an accepted hit this frame even when its damage was zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_true    <= MAX_H;
      r_pending <= '0;
      r_armed   <= 1'b0;
      r_invuln  <= '0;
    end else if (i_reload) begin
      r_true    <= MAX_H;
      r_pending <= '0;
      r_armed   <= 1'b0;
      r_invuln  <= '0;
    end else if (w_tick) begin
      r_true    <= w_true_next;
      r_pending <= w_accept ? {1'b0, i_dmg} : '0;
      r_armed   <= w_accept;
      if (r_armed)             r_invuln <= INV_F;
      else if (r_invuln != '0) r_invuln <= r_invuln - 8'd1;
    end else if (w_accept) begin
      r_pending <= w_pend_add;
      r_armed   <= 1'b1;
    end
  end

  assign o_true_health = r_true;
  assign o_zero        = (w_true_next == '0);

`ifdef HEALTH_DRAIN_ANIM_EN
  localparam logic [7:0] STEP = 8'(DRAIN_STEP);

  logic [7:0] r_disp;
  logic [7:0] w_target;

  // Drain runs on every tick, so the bar keeps falling after the round ends.
  assign w_target = w_tick ? w_true_next : r_true;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_disp <= MAX_H;
    end else if (i_reload) begin
      r_disp <= MAX_H;
    end else if (i_tick) begin
      if (r_disp > w_target) begin
        r_disp <= ((r_disp - w_target) > STEP) ? (r_disp - STEP) : w_target;
      end else begin
        r_disp <= w_target;
      end
    end
  end

  assign o_disp_health = r_disp;
`else
  assign o_disp_health = r_true;
`endif

endmodule

// File: rtl/health_manager.sv
// Round FSM and winner logic over two player_health instances.
// Optional displayed-health drain animation: HEALTH_DRAIN_ANIM_EN.
module health_manager
  import health_pkg::*;
#(
  parameter int unsigned MAX_HEALTH    = MAX_HEALTH_C,
  parameter int unsigned INVULN_FRAMES = INVULN_FRAMES_C
`ifdef HEALTH_DRAIN_ANIM_EN
  , parameter int unsigned DRAIN_STEP  = 2
`endif
) (
  input  logic       vga_clk,
  input  logic       Reset_n,
  input  logic       frame_tick,
  input  logic       round_start,
  input  logic       ryu_hit,
  input  logic [7:0] ryu_dmg,
  input  logic       akuma_hit,
  input  logic [7:0] akuma_dmg,
  output logic [7:0] RyuHealth,
  output logic [7:0] AkumaHealth,
  output logic       fight_active,
  output logic       ko,
  output logic [1:0] winner
);

  state_t     r_state;
  state_t     w_state_next;
  logic [1:0] r_winner;
  logic [1:0] w_winner_next;
  logic       w_en;
  logic       w_ryu_zero;
  logic       w_akuma_zero;
  logic [7:0] w_ryu_true;
  logic [7:0] w_akuma_true;

  assign w_en = (r_state == ST_FIGHT);

  player_health #(
    .MAX_HEALTH   (MAX_HEALTH),
    .INVULN_FRAMES(INVULN_FRAMES)
`ifdef HEALTH_DRAIN_ANIM_EN
    , .DRAIN_STEP (DRAIN_STEP)
`endif
  ) u_ryu (
    .i_clk        (vga_clk),
    .i_rst_n      (Reset_n),
    .i_reload     (round_start),
    .i_en         (w_en),
    .i_tick       (frame_tick),
    .i_hit        (ryu_hit),
    .i_dmg        (ryu_dmg),
    .o_true_health(w_ryu_true),
    .o_disp_health(RyuHealth),
    .o_zero       (w_ryu_zero)
  );

  player_health #(
    .MAX_HEALTH   (MAX_HEALTH),
    .INVULN_FRAMES(INVULN_FRAMES)
`ifdef HEALTH_DRAIN_ANIM_EN
    , .DRAIN_STEP (DRAIN_STEP)
`endif
  ) u_akuma (
    .i_clk        (vga_clk),
    .i_rst_n      (Reset_n),
    .i_reload     (round_start),
    .i_en         (w_en),
    .i_tick       (frame_tick),
    .i_hit        (akuma_hit),
    .i_dmg        (akuma_dmg),
    .o_true_health(w_akuma_true),
    .o_disp_health(AkumaHealth),
    .o_zero       (w_akuma_zero)
  );

  always_ff @(posedge vga_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state  <= ST_IDLE;
      r_winner <= WIN_NONE;
    end else begin
      r_state  <= w_state_next;
      r_winner <= w_winner_next;
    end
  end

  // o_zero reflects health after this tick's damage, so KO lands on the same edge.
  always_comb begin
    w_state_next  = r_state;
    w_winner_next = r_winner;
    case (r_state)
      ST_IDLE: begin
        if (round_start) begin
          w_state_next  = ST_FIGHT;
          w_winner_next = WIN_NONE;
        end
      end
      ST_FIGHT: begin
        if (round_start) begin
          w_winner_next = WIN_NONE;
        end else if (frame_tick && (w_ryu_zero || w_akuma_zero)) begin
          w_state_next = ST_KO;
          if (w_ryu_zero && w_akuma_zero) w_winner_next = WIN_DOUBLE;
          else if (w_akuma_zero)          w_winner_next = WIN_RYU;
          else                            w_winner_next = WIN_AKUMA;
        end
      end
      ST_KO: begin
        if (round_start) begin
          w_state_next  = ST_FIGHT;
          w_winner_next = WIN_NONE;
        end
      end
      default: begin
        w_state_next  = ST_IDLE;
        w_winner_next = WIN_NONE;
      end
    endcase
  end

  assign fight_active = (r_state == ST_FIGHT);
  assign ko           = (r_state == ST_KO);
  assign winner       = r_winner;

endmodule

// File: tb/tb_health_manager.sv
// Directed bench for health_manager with a frame-level reference model.
module tb_health_manager;

  localparam int MAXH = 245;
  localparam int INV  = 30;
  localparam int STEP = 2;

  logic       vga_clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       round_start = 1'b0;
  logic       ryu_hit = 1'b0;
  logic [7:0] ryu_dmg = '0;
  logic       akuma_hit = 1'b0;
  logic [7:0] akuma_dmg = '0;
  logic [7:0] RyuHealth;
  logic [7:0] AkumaHealth;
  logic       fight_active;
  logic       ko;
  logic [1:0] winner;

  int vectors = 0;
  int errors  = 0;

  health_manager dut (
    .vga_clk     (vga_clk),
    .Reset_n     (Reset_n),
    .frame_tick  (frame_tick),
    .round_start (round_start),
    .ryu_hit     (ryu_hit),
    .ryu_dmg     (ryu_dmg),
    .akuma_hit   (akuma_hit),
    .akuma_dmg   (akuma_dmg),
    .RyuHealth   (RyuHealth),
    .AkumaHealth (AkumaHealth),
    .fight_active(fight_active),
    .ko          (ko),
    .winner      (winner)
  );

  always #5 vga_clk = ~vga_clk;

  // Reference model: index 0 = Ryu, 1 = Akuma; phase 0 idle, 1 fight, 2 ko.
  int m_health[2];
  int m_shown[2];
  int m_owed[2];
  int m_frames_left[2];
  bit m_struck[2];
  int m_phase;
  int m_winner;

  task automatic model_reload();
    for (int p = 0; p < 2; p++) begin
      m_health[p] = MAXH; m_shown[p] = MAXH; m_owed[p] = 0;
      m_frames_left[p] = 0; m_struck[p] = 0;
    end
    m_winner = 0;
  endtask

  always @(posedge vga_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      model_reload();
      m_phase = 0;
    end else if (round_start) begin
      model_reload();
      m_phase = 1;
    end else begin
      bit hit[2];
      int dmg[2];
      bit took[2];
      bit fighting;
      hit[0] = ryu_hit;   dmg[0] = int'(ryu_dmg);
      hit[1] = akuma_hit; dmg[1] = int'(akuma_dmg);
      fighting = (m_phase == 1);
      for (int p = 0; p < 2; p++) begin
        took[p] = fighting && hit[p] && (m_frames_left[p] == 0);
        if (fighting && frame_tick) begin
          m_health[p] = (m_owed[p] >= m_health[p]) ? 0 : m_health[p] - m_owed[p];
          if (m_struck[p]) m_frames_left[p] = INV;
          else if (m_frames_left[p] > 0) m_frames_left[p]--;
          m_owed[p]   = took[p] ? dmg[p] : 0;
          m_struck[p] = took[p];
        end else if (took[p]) begin
          m_owed[p]   = (m_owed[p] + dmg[p] > 255) ? 255 : m_owed[p] + dmg[p];
          m_struck[p] = 1;
        end
        if (frame_tick) begin
`ifdef HEALTH_DRAIN_ANIM_EN
          if (m_shown[p] - m_health[p] > STEP) m_shown[p] = m_shown[p] - STEP;
          else m_shown[p] = m_health[p];
`else
          m_shown[p] = m_health[p];
`endif
        end
      end
      if (fighting && frame_tick && (m_health[0] == 0 || m_health[1] == 0)) begin
        m_phase  = 2;
        m_winner = (m_health[1] == 0 ? 1 : 0) + (m_health[0] == 0 ? 2 : 0);
      end
    end
  end

  always @(negedge vga_clk) begin
    if ($time > 20) begin
      vectors++;
      if (int'(RyuHealth) != m_shown[0] || int'(AkumaHealth) != m_shown[1] ||
          fight_active != (m_phase == 1) || ko != (m_phase == 2) || int'(winner) != m_winner) begin
        errors++;
        $display("FAIL model t=%0t: got ryu=%0d aku=%0d fa=%0b ko=%0b win=%0d, want ryu=%0d aku=%0d fa=%0b ko=%0b win=%0d",
                 $time, RyuHealth, AkumaHealth, fight_active, ko, winner,
                 m_shown[0], m_shown[1], m_phase == 1, m_phase == 2, m_winner);
      end
    end
  end

  task automatic check_lit(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic pulse(input logic r, input int dr, input logic a, input int da,
                       input logic tk, input logic rs);
    @(posedge vga_clk); #1;
    ryu_hit = r;   ryu_dmg = 8'(dr);
    akuma_hit = a; akuma_dmg = 8'(da);
    frame_tick = tk; round_start = rs;
    @(posedge vga_clk); #1;
    ryu_hit = 0; akuma_hit = 0; frame_tick = 0; round_start = 0;
    ryu_dmg = '0; akuma_dmg = '0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) pulse(0, 0, 0, 0, 1, 0);
  endtask

  initial begin
    Reset_n = 0;
    repeat (3) @(posedge vga_clk);
    #1;
    check_lit("reset_ryu", int'(RyuHealth), 245);
    check_lit("reset_fight", int'(fight_active), 0);
    check_lit("reset_winner", int'(winner), 0);
    Reset_n = 1;

    pulse(0, 0, 0, 0, 0, 1);
    ticks(3);
    check_lit("start_ryu", int'(RyuHealth), 245);
    check_lit("start_aku", int'(AkumaHealth), 245);
    check_lit("start_fight", int'(fight_active), 1);
    check_lit("start_ko", int'(ko), 0);

    pulse(1, 40, 0, 0, 0, 0);
    ticks(1);
`ifndef HEALTH_DRAIN_ANIM_EN
    check_lit("ryu_hit40", int'(RyuHealth), 205);
`endif
    ticks(5);
    pulse(1, 40, 0, 0, 0, 0);
    ticks(1);
`ifndef HEALTH_DRAIN_ANIM_EN
    check_lit("ryu_invuln_drop", int'(RyuHealth), 205);
`endif
    ticks(26);
    pulse(1, 40, 0, 0, 0, 0);
    ticks(1);
`ifndef HEALTH_DRAIN_ANIM_EN
    check_lit("ryu_second_hit", int'(RyuHealth), 165);
`endif

    pulse(0, 0, 1, 20, 0, 0);
    pulse(0, 0, 1, 30, 0, 0);
    pulse(0, 0, 1, 10, 1, 0);
`ifndef HEALTH_DRAIN_ANIM_EN
    check_lit("aku_two_hits", int'(AkumaHealth), 195);
`endif
    ticks(1);
`ifndef HEALTH_DRAIN_ANIM_EN
    check_lit("aku_tick_coincident", int'(AkumaHealth), 185);
`endif

    ticks(31);
    pulse(1, 155, 0, 0, 0, 0);
    ticks(1);
    ticks(31);
    pulse(1, 200, 0, 0, 0, 0);
    ticks(1);
    check_lit("ko_ryu_true", int'(dut.w_ryu_true), 0);
    check_lit("ko_flag", int'(ko), 1);
    check_lit("ko_winner", int'(winner), 2);
    pulse(0, 0, 1, 50, 0, 0);
    ticks(2);
    check_lit("ko_aku_frozen", int'(dut.w_akuma_true), 185);
    pulse(0, 0, 0, 0, 0, 1);
    check_lit("restart_ryu", int'(RyuHealth), 245);
    check_lit("restart_fight", int'(fight_active), 1);

    pulse(1, 0, 0, 0, 0, 0);
    ticks(1);
    pulse(1, 50, 0, 0, 0, 0);
    ticks(1);
    check_lit("dmg0_arms", int'(dut.w_ryu_true), 245);

    pulse(0, 0, 0, 0, 0, 1);
    pulse(1, 240, 1, 240, 0, 0);
    ticks(1);
    ticks(31);
    pulse(1, 5, 1, 5, 0, 0);
    ticks(1);
    check_lit("double_ko", int'(ko), 1);
    check_lit("double_winner", int'(winner), 3);

`ifdef HEALTH_DRAIN_ANIM_EN
    pulse(0, 0, 0, 0, 0, 1);
    pulse(1, 5, 0, 0, 0, 0);
    ticks(1);
    check_lit("drain_1", int'(RyuHealth), 243);
    ticks(1);
    check_lit("drain_2", int'(RyuHealth), 241);
    ticks(1);
    check_lit("drain_3", int'(RyuHealth), 240);
`endif

    pulse(0, 0, 0, 0, 0, 1);
    pulse(0, 0, 1, 5, 0, 0);
    ticks(1);
`ifdef HEALTH_DRAIN_ANIM_EN
    check_lit("mid_drain_aku", int'(AkumaHealth), 243);
`else
    check_lit("mid_fight_aku", int'(AkumaHealth), 240);
`endif
    Reset_n = 0;
    #1;
    check_lit("async_rst_aku", int'(AkumaHealth), 245);
    check_lit("async_rst_fight", int'(fight_active), 0);
    repeat (2) @(posedge vga_clk);
    #1;
    Reset_n = 1;
    repeat (2) @(posedge vga_clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
